// File: rtl/usrt_pkg.sv
// usrt_pkg: shared definitions for the USRT receive path.
//   par_mode_e          parity-mode encodings carried on i_Parity
//   *_idx / data_*      bit positions of the frame fields as functions of the data width
package usrt_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_MARK = 2'b11
  } par_mode_e;

  function automatic int start_idx();
    return 0;
  endfunction

  function automatic int data_lsb();
    return 1;
  endfunction

  function automatic int data_msb(input int w);
    return w;
  endfunction

  function automatic int par_idx(input int w);
    return w + 1;
  endfunction

  function automatic int stop1_idx(input int w);
    return w + 2;
  endfunction

  function automatic int stop2_idx(input int w);
    return w + 3;
  endfunction

endpackage

// File: rtl/rx_frame_check_if.sv
// rx_frame_check_if: frame-in / word-out handshake bundle of rx_frame_check.
//   i_Valid, i_Data        raw frame from the deserialiser (upstream -> checker)
//   o_Ready                checker can accept a frame
//   o_Valid, o_Data,
//   o_ParityErr,
//   o_FrameErr             buffered head word and its flags (checker -> consumer)
//   i_Ready                consumer takes the head word
// modport slave is the checker's view, modport master the surrounding system's view.
interface rx_frame_check_if #(
  parameter int DATA_W = 8
);
  logic              i_Valid;
  logic [DATA_W+3:0] i_Data;
  logic              o_Ready;
  logic              o_Valid;
  logic              i_Ready;
  logic [DATA_W-1:0] o_Data;
  logic              o_ParityErr;
  logic              o_FrameErr;

  modport master (
    output i_Valid, i_Data, i_Ready,
    input  o_Ready, o_Valid, o_Data, o_ParityErr, o_FrameErr
  );

  modport slave (
    input  i_Valid, i_Data, i_Ready,
    output o_Ready, o_Valid, o_Data, o_ParityErr, o_FrameErr
  );
endinterface

// File: rtl/rx_fifo.sv
// rx_fifo: synchronous first-word-fall-through FIFO.
//   i_Pclk, i_Rst        clock, synchronous active-high reset (pointers/flags only)
//   i_WrEn, i_WrData     write request; ignored while o_Full
//   o_Full               registered full flag
//   i_RdEn               pop request; ignored while o_Empty
//   o_RdData             head word, forced to 0 while empty
//   o_Empty              registered empty flag
module rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             i_Pclk,
  input  logic             i_Rst,
  input  logic             i_WrEn,
  input  logic [WIDTH-1:0] i_WrData,
  output logic             o_Full,
  input  logic             i_RdEn,
  output logic [WIDTH-1:0] o_RdData,
  output logic             o_Empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             push;
  logic             pop;

  assign push = i_WrEn & ~o_Full;
  assign pop  = i_RdEn & ~o_Empty;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_Pclk) begin
    if (i_Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_Full  <= 1'b0;
      o_Empty <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      o_Full  <= (count_nxt == FULL_CNT);
      o_Empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge i_Pclk) begin
    if (push) mem[wr_ptr] <= i_WrData;
  end

  // Storage is not reset, so the head is masked while empty to present zeros.
  assign o_RdData = o_Empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rx_frame_check.sv
// rx_frame_check: USRT receive-frame checker with output FIFO.
// Checks start/stop framing and parity of each captured frame, strips the
// overhead bits and queues {data, parity error, framing error}.
//   i_Pclk, i_Rst        clock, synchronous active-high reset
//   i_Parity             00 none, 01 even, 10 odd, 11 mark (sampled per frame)
//   i_Stop2              1 = second stop bit is checked
//   bus (slave)          frame input handshake and buffered word output
//   o_Overrun            one-cycle pulse after a frame was dropped on a full FIFO
//   i_CntClr             clears the error counters
//   o_*ErrCnt, o_OverrunCnt  saturating error counters
// Build option: define RXCHK_ERRCNT_EN to implement the counters; otherwise
// they read 0 and i_CntClr is ignored.
module rx_frame_check
  import usrt_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              i_Pclk,
  input  logic              i_Rst,
  input  logic [1:0]        i_Parity,
  input  logic              i_Stop2,
  rx_frame_check_if.slave   bus,
  output logic              o_Overrun,
  input  logic              i_CntClr,
  output logic [CNT_W-1:0]  o_ParityErrCnt,
  output logic [CNT_W-1:0]  o_FrameErrCnt,
  output logic [CNT_W-1:0]  o_OverrunCnt
);

  function automatic logic parity_err(input par_mode_e mode,
                                      input logic [DATA_W-1:0] data,
                                      input logic pbit);
    case (mode)
      PAR_EVEN: return ^{data, pbit};
      PAR_ODD:  return ~^{data, pbit};
      PAR_MARK: return ~pbit;
      default:  return 1'b0;
    endcase
  endfunction

  logic [DATA_W-1:0] data_p0;
  logic              perr_p0;
  logic              ferr_p0;
  logic              accept_p0;
  logic              drop_p0;
  logic              full;
  logic              empty;
  logic              overrun_p1;

  // Stage p0: combinational check of the frame presented this cycle.
  assign data_p0 = bus.i_Data[data_msb(DATA_W):data_lsb()];
  assign perr_p0 = parity_err(par_mode_e'(i_Parity), data_p0,
                              bus.i_Data[par_idx(DATA_W)]);
  assign ferr_p0 = bus.i_Data[start_idx()] | ~bus.i_Data[stop1_idx(DATA_W)]
                 | (i_Stop2 & ~bus.i_Data[stop2_idx(DATA_W)]);

  // Full is registered, so a frame arriving while full is lost even when the
  // consumer pops in the same cycle; the serial line cannot be stalled.
  assign accept_p0 = bus.i_Valid & ~full;
  assign drop_p0   = bus.i_Valid & full;

  rx_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_Pclk   (i_Pclk),
    .i_Rst    (i_Rst),
    .i_WrEn   (bus.i_Valid),
    .i_WrData ({data_p0, perr_p0, ferr_p0}),
    .o_Full   (full),
    .i_RdEn   (bus.i_Ready),
    .o_RdData ({bus.o_Data, bus.o_ParityErr, bus.o_FrameErr}),
    .o_Empty  (empty)
  );

  assign bus.o_Ready = ~full;
  assign bus.o_Valid = ~empty;

  // Stage p1: overrun pulse registered one cycle after the drop.
  always_ff @(posedge i_Pclk) begin
    if (i_Rst) overrun_p1 <= 1'b0;
    else       overrun_p1 <= drop_p0;
  end

  assign o_Overrun = overrun_p1;

`ifdef RXCHK_ERRCNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    if (inc && (v != '1)) return v + 1'b1;
    return v;
  endfunction

  logic [CNT_W-1:0] perr_cnt_p1;
  logic [CNT_W-1:0] ferr_cnt_p1;
  logic [CNT_W-1:0] ovr_cnt_p1;

  // Stage p1: counters; a clear in the same cycle as an increment wins.
  always_ff @(posedge i_Pclk) begin
    if (i_Rst || i_CntClr) begin
      perr_cnt_p1 <= '0;
      ferr_cnt_p1 <= '0;
      ovr_cnt_p1  <= '0;
    end else begin
      perr_cnt_p1 <= sat_inc(perr_cnt_p1, accept_p0 & perr_p0);
      ferr_cnt_p1 <= sat_inc(ferr_cnt_p1, accept_p0 & ferr_p0);
      ovr_cnt_p1  <= sat_inc(ovr_cnt_p1, drop_p0);
    end
  end

  assign o_ParityErrCnt = perr_cnt_p1;
  assign o_FrameErrCnt  = ferr_cnt_p1;
  assign o_OverrunCnt   = ovr_cnt_p1;
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = i_CntClr ^ accept_p0;

  assign o_ParityErrCnt = '0;
  assign o_FrameErrCnt  = '0;
  assign o_OverrunCnt   = '0;
`endif

endmodule

// File: tb/tb_rx_frame_check.sv
`timescale 1ns/1ps
module tb_rx_frame_check;
  import usrt_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
`ifdef RXCHK_ERRCNT_EN
  localparam int CNT_W  = 2;
`else
  localparam int CNT_W  = 16;
`endif
  localparam int FW = DATA_W + 4;

  typedef logic [DATA_W+1:0] word_t;
  typedef struct {
    logic [1:0]        p;
    logic              s2;
    logic [FW-1:0]     f;
    logic [DATA_W-1:0] d;
    logic              pe;
    logic              fe;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       par;
  logic             stop2;
  logic             cnt_clr;
  logic             overrun;
  logic [CNT_W-1:0] pcnt, fcnt, ocnt;

  rx_frame_check_if #(.DATA_W(DATA_W)) bus ();

  rx_frame_check #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_Pclk         (clk),
    .i_Rst          (rst),
    .i_Parity       (par),
    .i_Stop2        (stop2),
    .bus            (bus),
    .o_Overrun      (overrun),
    .i_CntClr       (cnt_clr),
    .o_ParityErrCnt (pcnt),
    .o_FrameErrCnt  (fcnt),
    .o_OverrunCnt   (ocnt)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  word_t sb[$];
  vec_t  tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic st, input logic [DATA_W-1:0] d,
                                       input logic pb, input logic s1, input logic s2);
    return {s2, s1, pb, d, st};
  endfunction

  // Reference: count ones over data+parity bit, decide per mode.
  function automatic word_t model(input logic [1:0] p, input logic s2, input logic [FW-1:0] f);
    int   c;
    logic pe, fe;
    c = 0;
    for (int i = 1; i <= DATA_W + 1; i++) c += int'(f[i]);
    case (p)
      2'b01:   pe = (c % 2) == 1;
      2'b10:   pe = (c % 2) == 0;
      2'b11:   pe = (f[DATA_W+1] == 1'b0);
      default: pe = 1'b0;
    endcase
    fe = (f[0] == 1'b1) || (f[DATA_W+2] == 1'b0) || (s2 && f[DATA_W+3] == 1'b0);
    return {f[DATA_W:1], pe, fe};
  endfunction

  // Called just after a posedge; presents one frame for one cycle.
  task automatic send(input logic [1:0] p, input logic s2, input logic [FW-1:0] f,
                      input word_t exp, input bit accept);
    par         = p;
    stop2       = s2;
    bus.i_Data  = f;
    bus.i_Valid = 1'b1;
    if (accept) sb.push_back(exp);
    @(posedge clk); #1;
    bus.i_Valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    bus.i_Ready = 1'b1;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", sb.size(), 0);
  endtask

  // Scoreboard: a pop happens at the next posedge whenever o_Valid & i_Ready.
  always @(negedge clk) begin
    if (!rst && bus.o_Valid && bus.i_Ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", {22'd0, bus.o_Data, bus.o_ParityErr, bus.o_FrameErr}, 32'hFFFF_FFFF);
      end else begin
        word_t e;
        e = sb.pop_front();
        chk("out_data", bus.o_Data, e[DATA_W+1:2]);
        chk("out_perr", bus.o_ParityErr, e[1]);
        chk("out_ferr", bus.o_FrameErr, e[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    rp;
    logic          rs2;
    logic [FW-1:0] rf;

    rst = 1'b1; bus.i_Valid = 1'b0; bus.i_Data = '0; bus.i_Ready = 1'b0;
    par = 2'b00; stop2 = 1'b0; cnt_clr = 1'b0;

    tbl[0]  = '{PAR_EVEN, 1'b0, mk(1'b0, 8'hA5, 1'b0, 1'b1, 1'b1), 8'hA5, 1'b0, 1'b0};
    tbl[1]  = '{PAR_ODD,  1'b0, mk(1'b0, 8'hA5, 1'b0, 1'b1, 1'b1), 8'hA5, 1'b1, 1'b0};
    tbl[2]  = '{PAR_MARK, 1'b0, mk(1'b0, 8'hA5, 1'b0, 1'b1, 1'b1), 8'hA5, 1'b1, 1'b0};
    tbl[3]  = '{PAR_NONE, 1'b0, mk(1'b0, 8'hA5, 1'b0, 1'b1, 1'b1), 8'hA5, 1'b0, 1'b0};
    tbl[4]  = '{PAR_EVEN, 1'b1, mk(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0), 8'hA5, 1'b0, 1'b1};
    tbl[5]  = '{PAR_EVEN, 1'b0, mk(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0), 8'hA5, 1'b0, 1'b0};
    tbl[6]  = '{PAR_EVEN, 1'b0, mk(1'b1, 8'hA5, 1'b0, 1'b1, 1'b1), 8'hA5, 1'b0, 1'b1};
    tbl[7]  = '{PAR_EVEN, 1'b0, mk(1'b0, 8'h01, 1'b1, 1'b1, 1'b1), 8'h01, 1'b0, 1'b0};
    tbl[8]  = '{PAR_ODD,  1'b0, mk(1'b0, 8'h01, 1'b0, 1'b1, 1'b1), 8'h01, 1'b0, 1'b0};
    tbl[9]  = '{PAR_MARK, 1'b1, mk(1'b0, 8'h3C, 1'b1, 1'b0, 1'b1), 8'h3C, 1'b0, 1'b1};
    tbl[10] = '{PAR_NONE, 1'b0, mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b1), 8'hFF, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",   bus.o_Valid, 0);
    chk("rst_ready",   bus.o_Ready, 1);
    chk("rst_data",    bus.o_Data, 0);
    chk("rst_perr",    bus.o_ParityErr, 0);
    chk("rst_ferr",    bus.o_FrameErr, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_pcnt",    pcnt, 0);
    chk("rst_fcnt",    fcnt, 0);
    chk("rst_ocnt",    ocnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors, back to back with the consumer always ready.
    bus.i_Ready = 1'b1;
    chk("pre_accept_valid", bus.o_Valid, 0);
    for (int i = 0; i < 11; i++) begin
      send(tbl[i].p, tbl[i].s2, tbl[i].f, {tbl[i].d, tbl[i].pe, tbl[i].fe}, 1'b1);
      if (i == 0) chk("latency1_valid", bus.o_Valid, 1);
    end
    drain(20);

    // Fill to full, then one dropped frame.
    bus.i_Ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rf = mk(1'b0, DATA_W'(8'h10 + i), 1'b0, 1'b1, 1'b1);
      send(PAR_EVEN, 1'b0, rf, model(PAR_EVEN, 1'b0, rf), 1'b1);
      chk("fill_overrun", overrun, 0);
    end
    chk("full_ready", bus.o_Ready, 0);
    chk("full_valid", bus.o_Valid, 1);
    rf = mk(1'b0, 8'h99, 1'b0, 1'b1, 1'b1);
    send(PAR_EVEN, 1'b0, rf, '0, 1'b0);
    chk("ovr_pulse", overrun, 1);
    chk("ovr_still_full", bus.o_Ready, 0);
    @(posedge clk); #1;
    chk("ovr_pulse_end", overrun, 0);
`ifdef RXCHK_ERRCNT_EN
    chk("ovr_cnt1", ocnt, 1);
`else
    chk("ovr_cnt_off", ocnt, 0);
`endif

    // Frame arriving while full but with a pop in the same cycle is still dropped.
    bus.i_Ready = 1'b1;
    rf = mk(1'b0, 8'h77, 1'b0, 1'b1, 1'b1);
    send(PAR_EVEN, 1'b0, rf, '0, 1'b0);
    chk("ovr_pop_pulse", overrun, 1);
    chk("ovr_pop_ready", bus.o_Ready, 1);
`ifdef RXCHK_ERRCNT_EN
    chk("ovr_cnt2", ocnt, 2);
`endif
    drain(20);
    chk("drained_valid", bus.o_Valid, 0);

    // Continuous stream, push and pop every cycle.
    bus.i_Ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rp  = 2'($urandom_range(0, 3));
      rs2 = 1'($urandom_range(0, 1));
      rf  = FW'($urandom);
      send(rp, rs2, rf, model(rp, rs2, rf), 1'b1);
      chk("stream_valid", bus.o_Valid, 1);
    end
    drain(20);

    // Reset with queued words discards them.
    bus.i_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rf = mk(1'b0, DATA_W'(8'h40 + i), 1'b0, 1'b1, 1'b1);
      send(PAR_NONE, 1'b0, rf, model(PAR_NONE, 1'b0, rf), 1'b1);
    end
    chk("queued_valid", bus.o_Valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", bus.o_Valid, 0);
    chk("midrst_ready", bus.o_Ready, 1);
    chk("midrst_data",  bus.o_Data, 0);
    rst = 1'b0;
    sb.delete();
    @(posedge clk); #1;

    // Counters.
    bus.i_Ready = 1'b1;
    rf = mk(1'b0, 8'h01, 1'b0, 1'b1, 1'b1);
`ifdef RXCHK_ERRCNT_EN
    for (int i = 0; i < 5; i++) send(PAR_EVEN, 1'b0, rf, model(PAR_EVEN, 1'b0, rf), 1'b1);
    chk("pcnt_sat", pcnt, 3);
    chk("fcnt_zero", fcnt, 0);
    rf = mk(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
    cnt_clr = 1'b1;
    send(PAR_EVEN, 1'b0, rf, model(PAR_EVEN, 1'b0, rf), 1'b1);
    cnt_clr = 1'b0;
    chk("clr_wins_pcnt", pcnt, 0);
    chk("clr_wins_fcnt", fcnt, 0);
    chk("clr_ocnt", ocnt, 0);
    send(PAR_EVEN, 1'b0, rf, model(PAR_EVEN, 1'b0, rf), 1'b1);
    chk("after_clr_pcnt", pcnt, 1);
    chk("after_clr_fcnt", fcnt, 1);
`else
    cnt_clr = 1'b1;
    send(PAR_EVEN, 1'b0, rf, model(PAR_EVEN, 1'b0, rf), 1'b1);
    cnt_clr = 1'b0;
    send(PAR_EVEN, 1'b0, rf, model(PAR_EVEN, 1'b0, rf), 1'b1);
    chk("off_pcnt", pcnt, 0);
    chk("off_fcnt", fcnt, 0);
    chk("off_ocnt", ocnt, 0);
`endif
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
